// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// Master is the controller; slave is the datapath side.
interface multicycle_controller_if #(
  parameter int OP_W  = 7,
  parameter int CNT_W = 32
);
  logic [OP_W-1:0]  op;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write,
    output ir_write, reg_write, result_src,
    output alu_src_a, alu_src_b, alu_op,
    output imm_src, illegal, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write,
    input  ir_write, reg_write, result_src,
    input  alu_src_a, alu_src_b, alu_op,
    input  imm_src, illegal, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/
// memory/writeback, stalls on mem_ready, flags bad opcodes.
module multicycle_controller #(
  parameter int OP_W            = 7,
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_controller_if.master bus
);

  localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(35);
  localparam logic [OP_W-1:0] OP_R   = OP_W'(51);
  localparam logic [OP_W-1:0] OP_I   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(99);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(111);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             branch;
  logic             pc_update;
  logic             retire;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  // Sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state_n == S_ILLEGAL) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Next state and Moore control outputs (mem_ready gates stalls).
  always_comb begin
    state_n        = state;
    branch         = 1'b0;
    pc_update      = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    unique case (state)
      S_FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          pc_update    = 1'b1;
          state_n      = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        if (bus.op == OP_LW || bus.op == OP_SW)
          state_n = S_MEMADR;
        else if (bus.op == OP_R)   state_n = S_EXECR;
        else if (bus.op == OP_I)   state_n = S_EXECI;
        else if (bus.op == OP_BEQ) state_n = S_BEQ;
        else if (bus.op == OP_JAL) state_n = S_JAL;
        else                       state_n = S_ILLEGAL;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_n = (bus.op == OP_LW) ? S_MEMREAD
                                    : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        state_n        = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) state_n = S_FETCH;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        state_n       = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        state_n       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        state_n       = S_FETCH;
      end
      S_BEQ: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        branch        = 1'b1;
        state_n       = S_FETCH;
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pc_update     = 1'b1;
        state_n       = S_ALUWB;
      end
      S_ILLEGAL: begin
        state_n = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Retire on the step back to FETCH that completes an instruction.
  always_comb begin
    retire = 1'b0;
    if (state_n == S_FETCH)
      retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
               (state == S_ALUWB) || (state == S_BEQ);
  end

  // Immediate format straight from the opcode; unknown ops use I.
  always_comb begin
    bus.imm_src = 2'b00;
    if (bus.op == OP_SW)       bus.imm_src = 2'b01;
    else if (bus.op == OP_BEQ) bus.imm_src = 2'b10;
    else if (bus.op == OP_JAL) bus.imm_src = 2'b11;
  end

  assign bus.pc_write = (branch & bus.zero) | pc_update;
  assign bus.illegal  = illegal_q;
  assign bus.instret  = instret_q;

endmodule
